// File: rtl/dfi_phy_pkg.sv
// Shared types and constants for the DFI PHY responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dfi_phy_pkg;

  // Init handshake states; complete is reported only in READY.
  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    INIT_RUN   = 2'd1,
    READY      = 2'd2
  } init_state_e;

  // Returned in place of data when a read finds the loopback FIFO empty.
  localparam logic [31:0] UNDERFLOW_PAT = 32'hDEAD_BEEF;

  // Only one PHY update type is ever requested.
  localparam logic [1:0] PHYUPD_TYPE = 2'b00;

endpackage

// File: rtl/dfi_if.sv
// DFI bus between the memory controller (master) and the PHY (slave).
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; handshakes are req/ack level pairs.
interface dfi_if #(
  parameter int DATA_W = 64
);
  logic                  dfi_init_start;
  logic                  dfi_init_complete;
  logic                  dfi_wrdata_en;
  logic [DATA_W-1:0]     dfi_wrdata;
  logic [DATA_W/8-1:0]   dfi_wrdata_mask;
  logic                  dfi_rddata_en;
  logic [DATA_W-1:0]     dfi_rddata;
  logic                  dfi_rddata_valid;
  logic                  dfi_ctrlupd_req;
  logic                  dfi_ctrlupd_ack;
  logic                  dfi_phyupd_req;
  logic [1:0]            dfi_phyupd_type;
  logic                  dfi_phyupd_ack;

  modport master (
    output dfi_init_start, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
           dfi_rddata_en, dfi_ctrlupd_req, dfi_phyupd_ack,
    input  dfi_init_complete, dfi_rddata, dfi_rddata_valid,
           dfi_ctrlupd_ack, dfi_phyupd_req, dfi_phyupd_type
  );

  modport slave (
    input  dfi_init_start, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
           dfi_rddata_en, dfi_ctrlupd_req, dfi_phyupd_ack,
    output dfi_init_complete, dfi_rddata, dfi_rddata_valid,
           dfi_ctrlupd_ack, dfi_phyupd_req, dfi_phyupd_type
  );
endinterface

// File: rtl/dfi_loopback_fifo.sv
// Synchronous loopback FIFO holding write data until the controller reads it back.
// Latency: push visible to pop the next cycle; dout_o is the head word, combinational.
// Backpressure: none; push while full and pop while empty are ignored (caller flags them).
// Ports: core_clk/core_arstn clock and async active-low reset; push_i/din_i write side;
//        pop_i/dout_o read side; full_o/empty_o occupancy status. FIFO_DEPTH >= 2, power of 2.
module dfi_loopback_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Extra MSB separates full from empty once the pointers have wrapped.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge core_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/dfi_phy_responder.sv
// DFI PHY stand-in: answers init/ctrlupd(/phyupd) handshakes and loops write data back as read data.
// Latency: init_complete INIT_CYCLES+1 after start; write capture WRLAT; read data exactly RDLAT.
// Backpressure: none; FIFO overflow drops data, underflow returns a fixed pattern, both sticky-flagged.
// Ports: core_clk, core_arstn (async active-low); s_dfi DFI slave end; err_overflow,
//        err_underflow, err_proto sticky error flags.
// Build option: define DFI_PHY_PHYUPD_EN to generate periodic PHY update requests.
module dfi_phy_responder
  import dfi_phy_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int INIT_CYCLES   = 16,
  parameter int WRLAT         = 2,
  parameter int RDLAT         = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int PHYUPD_PERIOD = 1024
) (
  input  logic  core_clk,
  input  logic  core_arstn,
  dfi_if.slave  s_dfi,
  output logic  err_overflow,
  output logic  err_underflow,
  output logic  err_proto
);
  localparam int PAT_REP = (DATA_W + 31) / 32;
  localparam logic [PAT_REP*32-1:0] PAT_FULL = {PAT_REP{UNDERFLOW_PAT}};

  init_state_e       state_q, state_d;
  logic [15:0]       init_cnt_q, init_cnt_d;
  logic              wr_push;
  logic [DATA_W-1:0] fifo_dout, rd_word;
  logic              fifo_full, fifo_empty;
  logic              ctrlupd_ack_q;
  logic              phyupd_req;
  logic              err_ovf_q, err_ovf_d, err_unf_q, err_unf_d, err_proto_q, err_proto_d;
  logic              unused_mask;

  assign unused_mask = ^s_dfi.dfi_wrdata_mask;

  // ---------------- init FSM ----------------
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      WAIT_START: if (s_dfi.dfi_init_start) begin
        state_d    = INIT_RUN;
        init_cnt_d = '0;
      end
      INIT_RUN: begin
        if (init_cnt_q == 16'(INIT_CYCLES - 1)) state_d = READY;
        else                                     init_cnt_d = init_cnt_q + 16'd1;
      end
      READY:   state_d = READY;
      default: state_d = WAIT_START;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q    <= WAIT_START;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign s_dfi.dfi_init_complete = (state_q == READY);

  // ---------------- write path: delay the enable, data arrives on the bus later ----------------
  if (WRLAT == 0) begin : g_wr_nodly
    assign wr_push = s_dfi.dfi_wrdata_en;
  end else begin : g_wr_dly
    logic [WRLAT-1:0] wr_en_q;
    always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
        wr_en_q <= '0;
      end else begin
        wr_en_q[0] <= s_dfi.dfi_wrdata_en;
        for (int i = 1; i < WRLAT; i++) wr_en_q[i] <= wr_en_q[i-1];
      end
    end
    assign wr_push = wr_en_q[WRLAT-1];
  end

  dfi_loopback_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .core_clk  (core_clk),
    .core_arstn(core_arstn),
    .push_i    (wr_push),
    .pop_i     (s_dfi.dfi_rddata_en),
    .din_i     (s_dfi.dfi_wrdata),
    .dout_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // ---------------- read path: pop now, present after RDLAT stages ----------------
  assign rd_word = fifo_empty ? PAT_FULL[DATA_W-1:0] : fifo_dout;

  logic [RDLAT-1:0]  rd_vld_q;
  logic [DATA_W-1:0] rd_dat_q [RDLAT];

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RDLAT; i++) rd_dat_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= s_dfi.dfi_rddata_en;
      rd_dat_q[0] <= s_dfi.dfi_rddata_en ? rd_word : '0;
      for (int i = 1; i < RDLAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
    end
  end

  assign s_dfi.dfi_rddata_valid = rd_vld_q[RDLAT-1];
  assign s_dfi.dfi_rddata       = rd_dat_q[RDLAT-1];

  // ---------------- ctrlupd: ack simply follows req one cycle late ----------------
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) ctrlupd_ack_q <= 1'b0;
    else             ctrlupd_ack_q <= s_dfi.dfi_ctrlupd_req;
  end
  assign s_dfi.dfi_ctrlupd_ack = ctrlupd_ack_q;

  // ---------------- phyupd ----------------
`ifdef DFI_PHY_PHYUPD_EN
  logic [31:0] phy_cnt_q, phy_cnt_d;
  logic        phy_req_q, phy_req_d;

  // Counter idles at zero while a request is outstanding, so the period restarts on drop.
  always_comb begin
    phy_cnt_d = phy_cnt_q;
    phy_req_d = phy_req_q;
    if (phy_req_q) begin
      if (s_dfi.dfi_phyupd_ack) begin
        phy_req_d = 1'b0;
        phy_cnt_d = '0;
      end
    end else if (state_q == READY) begin
      if (phy_cnt_q == 32'(PHYUPD_PERIOD - 1)) begin
        phy_req_d = 1'b1;
        phy_cnt_d = '0;
      end else begin
        phy_cnt_d = phy_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      phy_cnt_q <= '0;
      phy_req_q <= 1'b0;
    end else begin
      phy_cnt_q <= phy_cnt_d;
      phy_req_q <= phy_req_d;
    end
  end

  assign phyupd_req             = phy_req_q;
  assign s_dfi.dfi_phyupd_type  = PHYUPD_TYPE;
`else
  logic unused_phyupd_ack;
  localparam int unused_phyupd_period = PHYUPD_PERIOD;
  assign unused_phyupd_ack      = s_dfi.dfi_phyupd_ack;
  assign phyupd_req             = 1'b0;
  assign s_dfi.dfi_phyupd_type  = 2'b00;
`endif
  assign s_dfi.dfi_phyupd_req = phyupd_req;

  // ---------------- sticky errors ----------------
  // Full/empty are the start-of-cycle status, so a same-cycle pop never makes room for a push.
  always_comb begin
    err_ovf_d   = err_ovf_q | (wr_push & fifo_full);
    err_unf_d   = err_unf_q | (s_dfi.dfi_rddata_en & fifo_empty);
    err_proto_d = err_proto_q |
                  ((s_dfi.dfi_wrdata_en | s_dfi.dfi_rddata_en) & (ctrlupd_ack_q | phyupd_req));
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_proto     = err_proto_q;
endmodule

// File: tb/tb_dfi_phy_responder.sv
// Self-checking bench for dfi_phy_responder: directed table, hand sequences and a
// randomized run checked against a queue-based model of the loopback and handshakes.
module tb_dfi_phy_responder;
  localparam int DATA_W        = 64;
  localparam int INIT_CYCLES   = 16;
  localparam int WRLAT         = 2;
  localparam int RDLAT         = 4;
  localparam int FIFO_DEPTH    = 16;
  localparam int PHYUPD_PERIOD = 8;
  localparam logic [63:0] UF_WORD = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef DFI_PHY_PHYUPD_EN
  localparam bit PHY_EN = 1'b1;
`else
  localparam bit PHY_EN = 1'b0;
`endif

  logic core_clk = 1'b0;
  logic core_arstn;
  logic err_overflow, err_underflow, err_proto;

  dfi_if #(.DATA_W(DATA_W)) dfi ();

  dfi_phy_responder #(
    .DATA_W       (DATA_W),
    .INIT_CYCLES  (INIT_CYCLES),
    .WRLAT        (WRLAT),
    .RDLAT        (RDLAT),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .PHYUPD_PERIOD(PHYUPD_PERIOD)
  ) dut (
    .core_clk     (core_clk),
    .core_arstn   (core_arstn),
    .s_dfi        (dfi),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .err_proto    (err_proto)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    int          due;
    logic [63:0] dat;
  } ev_t;

  typedef struct {
    bit          we;
    logic [63:0] wd;
    bit          re;
    bit          exp_v;
    logic [63:0] exp_d;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  ev_t         wr_q[$];
  ev_t         rd_q[$];
  logic [63:0] mq[$];
  logic [63:0] got[$];
  bit          m_ovf, m_unf, m_proto, m_ack, m_started, m_phy, pa;
  int          m_s, m_phy_due;
  vec_t        tbl[17];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
    cyc++;
  endtask

  // One bus cycle: drive inputs for cycle cyc, advance the model, then check cycle cyc+1.
  task automatic do_cycle(input bit we, input logic [63:0] wd, input bit re,
                          input bit upd, input bit st);
    ev_t         e;
    bit          push_now;
    logic [63:0] pd;
    int          sz;
    bit          exp_v;
    logic [63:0] exp_d;
    bit          pa_s;
    if (we) begin
      e.due = cyc + WRLAT;
      e.dat = wd;
      wr_q.push_back(e);
    end
    push_now = 1'b0;
    pd       = '0;
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      pd = wr_q[0].dat;
      wr_q.delete(0);
      push_now = 1'b1;
    end
    dfi.dfi_wrdata_en   = we;
    dfi.dfi_wrdata      = pd;
    dfi.dfi_wrdata_mask = 8'($urandom);
    dfi.dfi_rddata_en   = re;
    dfi.dfi_ctrlupd_req = upd;
    dfi.dfi_init_start  = st;
    dfi.dfi_phyupd_ack  = pa;
    if ((we || re) && (m_ack || m_phy)) m_proto = 1'b1;
    sz = mq.size();
    if (re) begin
      e.due = cyc + RDLAT;
      if (sz == 0) begin
        m_unf = 1'b1;
        e.dat = UF_WORD;
      end else begin
        e.dat = mq.pop_front();
      end
      rd_q.push_back(e);
    end
    if (push_now) begin
      if (sz == FIFO_DEPTH) m_ovf = 1'b1;
      else                  mq.push_back(pd);
    end
    if (st && !m_started) begin
      m_started = 1'b1;
      m_s       = cyc;
      m_phy_due = cyc + 1 + INIT_CYCLES + PHYUPD_PERIOD;
    end
    pa_s = pa;
    tick();
    m_ack = upd;
    if (PHY_EN) begin
      if (m_phy) begin
        if (pa_s) begin
          m_phy     = 1'b0;
          m_phy_due = cyc + PHYUPD_PERIOD;
        end
      end else if (m_started && cyc >= m_phy_due) begin
        m_phy = 1'b1;
      end
    end
    exp_v = 1'b0;
    exp_d = '0;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      exp_v = 1'b1;
      exp_d = rd_q[0].dat;
      rd_q.delete(0);
    end
    chk1("rddata_valid", dfi.dfi_rddata_valid, exp_v);
    if (exp_v) begin
      chk64("rddata", dfi.dfi_rddata, exp_d);
      got.push_back(dfi.dfi_rddata);
    end
    chk1("ctrlupd_ack", dfi.dfi_ctrlupd_ack, m_ack);
    chk1("init_complete", dfi.dfi_init_complete, m_started && (cyc >= m_s + 1 + INIT_CYCLES));
    chk1("phyupd_req", dfi.dfi_phyupd_req, m_phy);
    chk64("phyupd_type", 64'(dfi.dfi_phyupd_type), 64'd0);
    chk1("err_overflow", err_overflow, m_ovf);
    chk1("err_underflow", err_underflow, m_unf);
    chk1("err_proto", err_proto, m_proto);
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from the clock edge, checks the reset state, clears the model.
  task automatic do_reset();
    core_arstn = 1'b0;
    #1;
    chk1("rst_rddata_valid", dfi.dfi_rddata_valid, 1'b0);
    chk64("rst_rddata", dfi.dfi_rddata, 64'd0);
    chk1("rst_init_complete", dfi.dfi_init_complete, 1'b0);
    chk1("rst_ctrlupd_ack", dfi.dfi_ctrlupd_ack, 1'b0);
    chk1("rst_phyupd_req", dfi.dfi_phyupd_req, 1'b0);
    chk64("rst_phyupd_type", 64'(dfi.dfi_phyupd_type), 64'd0);
    chk1("rst_err_overflow", err_overflow, 1'b0);
    chk1("rst_err_underflow", err_underflow, 1'b0);
    chk1("rst_err_proto", err_proto, 1'b0);
    wr_q.delete(); rd_q.delete(); mq.delete(); got.delete();
    m_ovf = 0; m_unf = 0; m_proto = 0; m_ack = 0; m_started = 0; m_phy = 0; pa = 0;
    m_s = 0; m_phy_due = 0;
    dfi.dfi_wrdata_en = 0; dfi.dfi_wrdata = '0; dfi.dfi_wrdata_mask = '0;
    dfi.dfi_rddata_en = 0; dfi.dfi_ctrlupd_req = 0; dfi.dfi_init_start = 0;
    dfi.dfi_phyupd_ack = 0;
    @(posedge core_clk);
    #3;
    core_arstn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Loopback table: rows are cycles 30..46; expectations are the outputs one cycle later.
    for (int r = 0; r < 17; r++) tbl[r] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0};
    tbl[0].we  = 1'b1; tbl[0].wd = 64'h1111;
    tbl[1].we  = 1'b1; tbl[1].wd = 64'h2222;
    tbl[10].re = 1'b1;
    tbl[11].re = 1'b1;
    tbl[13].exp_v = 1'b1; tbl[13].exp_d = 64'h1111;
    tbl[14].exp_v = 1'b1; tbl[14].exp_d = 64'h2222;

    core_arstn = 1'b1;
    #3;
    do_reset();

    while (cyc < 30) idle(1);
    for (int r = 0; r < 17; r++) begin
      do_cycle(tbl[r].we, tbl[r].wd, tbl[r].re, 1'b0, 1'b0);
      chk1("tbl_valid", dfi.dfi_rddata_valid, tbl[r].exp_v);
      if (tbl[r].exp_v) chk64("tbl_data", dfi.dfi_rddata, tbl[r].exp_d);
    end
    chk1("tbl_err_overflow", err_overflow, 1'b0);
    chk1("tbl_err_underflow", err_underflow, 1'b0);
    chk1("tbl_err_proto", err_proto, 1'b0);

    // Underflow: FIFO is empty after the table.
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(RDLAT - 1);
    chk1("unf_valid", dfi.dfi_rddata_valid, 1'b1);
    chk64("unf_data", dfi.dfi_rddata, 64'hDEAD_BEEF_DEAD_BEEF);
    idle(5);
    chk1("unf_sticky", err_underflow, 1'b1);

    // Overflow: 17 writes into 16 entries, then 16 reads.
    do_reset();
    for (int i = 1; i <= 17; i++) do_cycle(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    idle(WRLAT + 1);
    chk1("ovf_set", err_overflow, 1'b1);
    got.delete();
    for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(RDLAT + 1);
    chk64("ovf_read_count", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk64("ovf_read_data", (i < got.size()) ? got[i] : 64'hX, 64'(i + 1));
    chk1("ovf_no_underflow", err_underflow, 1'b0);

    // Reset in the middle of in-flight reads: nothing may come out afterwards.
    do_reset();
    do_cycle(1'b1, 64'hAAAA, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 64'hBBBB, 1'b0, 1'b0, 1'b0);
    idle(WRLAT);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    do_reset();
    got.delete();
    idle(RDLAT + 4);
    chk64("abort_no_valid", 64'(got.size()), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++)
      do_cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 99) < 45), 1'b0, 1'b0);
    idle(WRLAT + RDLAT + 2);

    // Ctrlupd: req over cycles 50..54 with a write at 52.
    do_reset();
    while (cyc < 50) idle(1);
    chk1("upd_ack_before", dfi.dfi_ctrlupd_ack, 1'b0);
    for (int c = 50; c <= 54; c++) begin
      do_cycle(c == 52, 64'hC0DE, 1'b0, 1'b1, 1'b0);
      chk1("upd_ack_high", dfi.dfi_ctrlupd_ack, 1'b1);
    end
    idle(1);
    chk1("upd_ack_low", dfi.dfi_ctrlupd_ack, 1'b0);
    chk1("upd_err_proto", err_proto, 1'b1);

    // Init at cycle 10, then PHY update timing and a repeated start.
    do_reset();
    while (cyc < 10) idle(1);
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    while (cyc < 26) idle(1);
    chk1("init_before", dfi.dfi_init_complete, 1'b0);
    idle(1);
    chk1("init_rise", dfi.dfi_init_complete, 1'b1);
    while (cyc < 34) idle(1);
    chk1("phyupd_early", dfi.dfi_phyupd_req, 1'b0);
    idle(1);
    chk1("phyupd_rise", dfi.dfi_phyupd_req, PHY_EN);
    while (cyc < 38) idle(1);
    pa = 1'b1;
    idle(1);
    pa = 1'b0;
    chk1("phyupd_drop", dfi.dfi_phyupd_req, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(5);
    chk1("init_hold", dfi.dfi_init_complete, 1'b1);
    while (cyc < 47) idle(1);
    chk1("phyupd_rerise", dfi.dfi_phyupd_req, PHY_EN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
